ov7670_capture_dec: RTL and testbench

OV7670_CAPTURE_DEC -- requirements
Module: ov7670_capture_dec

---
 rtl/ov7670_capture_dec.sv | 225 ++++++++++++++++++++++
 tb/tb_ov7670_capture_dec.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ov7670_capture_dec.sv
// OV7670 RGB565 capture with 2^C_DEC_SHIFT decimation into a frame buffer write port.
// Optional luma output is enabled by defining the macro CAPTURE_GRAY_EN (adds input gray_mode).
module ov7670_capture_dec #(
  parameter int C_IMG_COLS    = 80,
  parameter int C_IMG_ROWS    = 60,
  parameter int C_DEC_SHIFT   = 3,
  parameter int C_NB_IMG_PXLS = 13,
  parameter int C_NB_CNT      = 10
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     pclk,
  input  logic                     vsync,
  input  logic                     href,
  input  logic [7:0]               data,
  input  logic                     swap_r_b,
  input  logic                     freeze,
`ifdef CAPTURE_GRAY_EN
  input  logic                     gray_mode,
`endif
  output logic [C_NB_IMG_PXLS-1:0] addr,
  output logic [15:0]              dout,
  output logic                     we,
  output logic                     frame_done,
  output logic [7:0]               frame_cnt
);

  localparam int NB_WCNT = C_NB_IMG_PXLS + 1;
  localparam logic [NB_WCNT-1:0]  C_TOTAL    = NB_WCNT'(C_IMG_COLS * C_IMG_ROWS);
  localparam logic [C_NB_CNT-1:0] C_DEC_MASK = C_NB_CNT'((1 << C_DEC_SHIFT) - 1);
  localparam logic [C_NB_CNT-1:0] C_COLS_L   = C_NB_CNT'(C_IMG_COLS);
  localparam logic [C_NB_CNT-1:0] C_ROWS_L   = C_NB_CNT'(C_IMG_ROWS);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SYNC   = 2'd1,
    S_ACTIVE = 2'd2
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  logic       r_pclk_s1, r_pclk_s2, r_pclk_s3;
  logic       r_vsync_s1, r_vsync_s2, r_vsync_s3;
  logic       r_href_s1, r_href_s2, r_href_s3;
  logic [7:0] r_data_s1, r_data_s2;

  logic [C_NB_CNT-1:0]      r_col, r_row;
  logic                     r_have_hi;
  logic [7:0]               r_hi_byte;
  logic [NB_WCNT-1:0]       r_wr_cnt;
  logic                     r_freeze_lat;
  logic [C_NB_IMG_PXLS-1:0] r_addr;
  logic [15:0]              r_dout;
  logic                     r_we;
  logic                     r_frame_done;
  logic [7:0]               r_frame_cnt;

  logic        w_byte_stb, w_vs_rise, w_vs_fall, w_href_fall;
  logic        w_in_active, w_end_frame, w_line_byte, w_pix_stb;
  logic        w_keep, w_do_write;
  logic [15:0] w_rgb_raw, w_rgb, w_pix_out;
  logic [4:0]  w_r5, w_b5;
  logic [5:0]  w_g6;

  // Camera signals cross into clk through two flops; the third stage only feeds edge detection.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pclk_s1  <= 1'b0;
      r_pclk_s2  <= 1'b0;
      r_pclk_s3  <= 1'b0;
      r_vsync_s1 <= 1'b0;
      r_vsync_s2 <= 1'b0;
      r_vsync_s3 <= 1'b0;
      r_href_s1  <= 1'b0;
      r_href_s2  <= 1'b0;
      r_href_s3  <= 1'b0;
      r_data_s1  <= 8'h00;
      r_data_s2  <= 8'h00;
    end else begin
      r_pclk_s1  <= pclk;
      r_pclk_s2  <= r_pclk_s1;
      r_pclk_s3  <= r_pclk_s2;
      r_vsync_s1 <= vsync;
      r_vsync_s2 <= r_vsync_s1;
      r_vsync_s3 <= r_vsync_s2;
      r_href_s1  <= href;
      r_href_s2  <= r_href_s1;
      r_href_s3  <= r_href_s2;
      r_data_s1  <= data;
      r_data_s2  <= r_data_s1;
    end
  end

  assign w_byte_stb  = r_pclk_s2 & ~r_pclk_s3;
  assign w_vs_rise   = r_vsync_s2 & ~r_vsync_s3;
  assign w_vs_fall   = ~r_vsync_s2 & r_vsync_s3;
  assign w_href_fall = ~r_href_s2 & r_href_s3;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:   if (w_vs_rise) w_state_nxt = S_SYNC;
      S_SYNC:   if (w_vs_fall) w_state_nxt = S_ACTIVE;
      S_ACTIVE: if (w_vs_rise) w_state_nxt = S_SYNC;
      default:  w_state_nxt = S_IDLE;
    endcase
  end

  // A vsync rise in ACTIVE wins over any byte strobe in the same cycle, so a partial pixel is dropped.
  always_comb begin
    w_in_active = 1'b0;
    w_end_frame = 1'b0;
    case (r_state)
      S_ACTIVE: begin
        w_in_active = ~w_vs_rise;
        w_end_frame = w_vs_rise;
      end
      default: begin
        w_in_active = 1'b0;
        w_end_frame = 1'b0;
      end
    endcase
  end

  assign w_line_byte = w_in_active & w_byte_stb & r_href_s2;
  assign w_pix_stb   = w_line_byte & r_have_hi;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_have_hi <= 1'b0;
      r_hi_byte <= 8'h00;
    end else begin
      if (!w_in_active || w_href_fall) r_have_hi <= 1'b0;
      else if (w_line_byte)            r_have_hi <= ~r_have_hi;
      if (w_line_byte && !r_have_hi)   r_hi_byte <= r_data_s2;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_col <= '0;
      r_row <= '0;
    end else if (!w_in_active) begin
      r_col <= '0;
      r_row <= '0;
    end else if (w_href_fall) begin
      r_col <= '0;
      r_row <= r_row + 1'b1;
    end else if (w_pix_stb) begin
      r_col <= r_col + 1'b1;
    end
  end

  assign w_keep = w_pix_stb
                & ((r_col & C_DEC_MASK) == '0)
                & ((r_row & C_DEC_MASK) == '0)
                & ((r_col >> C_DEC_SHIFT) < C_COLS_L)
                & ((r_row >> C_DEC_SHIFT) < C_ROWS_L);

  assign w_do_write = w_keep & ~r_freeze_lat & (r_wr_cnt < C_TOTAL);

  assign w_rgb_raw = {r_hi_byte, r_data_s2};
  assign w_r5      = swap_r_b ? w_rgb_raw[4:0]   : w_rgb_raw[15:11];
  assign w_g6      = w_rgb_raw[10:5];
  assign w_b5      = swap_r_b ? w_rgb_raw[15:11] : w_rgb_raw[4:0];
  assign w_rgb     = {w_r5, w_g6, w_b5};

`ifdef CAPTURE_GRAY_EN
  logic [9:0] w_luma_sum;
  // Weights 1:2:1 on the channels expanded to 8 bits, divided by four.
  assign w_luma_sum = {2'b00, w_r5, 3'b000} + {1'b0, w_g6, 3'b000} + {2'b00, w_b5, 3'b000};
  assign w_pix_out  = gray_mode ? {8'h00, w_luma_sum[9:2]} : w_rgb;
`else
  assign w_pix_out  = w_rgb;
`endif

  // Write pointer restarts on every vsync rise, which is also when freeze takes effect.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_cnt     <= '0;
      r_addr       <= '0;
      r_freeze_lat <= 1'b0;
    end else if (w_vs_rise) begin
      r_wr_cnt     <= '0;
      r_addr       <= '0;
      r_freeze_lat <= freeze;
    end else if (w_do_write) begin
      r_wr_cnt     <= r_wr_cnt + 1'b1;
      r_addr       <= r_wr_cnt[C_NB_IMG_PXLS-1:0];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_we   <= 1'b0;
      r_dout <= 16'h0000;
    end else begin
      r_we <= w_do_write;
      if (w_do_write) r_dout <= w_pix_out;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_frame_done <= 1'b0;
      r_frame_cnt  <= 8'h00;
    end else begin
      r_frame_done <= w_end_frame & (r_wr_cnt == C_TOTAL);
      if (w_end_frame && (r_wr_cnt == C_TOTAL)) r_frame_cnt <= r_frame_cnt + 8'd1;
    end
  end

  assign addr       = r_addr;
  assign dout       = r_dout;
  assign we         = r_we;
  assign frame_done = r_frame_done;
  assign frame_cnt  = r_frame_cnt;

endmodule

// File: tb/tb_ov7670_capture_dec.sv
// Self-checking bench for ov7670_capture_dec on a scaled image (8x6 from 16x12 camera pixels).
// Build with CAPTURE_GRAY_EN defined to also exercise the luma path.
module tb_ov7670_capture_dec;

  localparam int COLS     = 8;
  localparam int ROWS     = 6;
  localparam int DEC      = 1;
  localparam int NBA      = 6;
  localparam int NBC      = 10;
  localparam int TOTAL    = COLS * ROWS;
  localparam int CAM_COLS = 18;
  localparam int CAM_ROWS = 14;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic           pclk = 1'b0;
  logic           vsync = 1'b0;
  logic           href = 1'b0;
  logic [7:0]     data = 8'h00;
  logic           swap_r_b = 1'b0;
  logic           freeze = 1'b0;
`ifdef CAPTURE_GRAY_EN
  logic           gray_mode = 1'b0;
`endif
  logic [NBA-1:0] addr;
  logic [15:0]    dout;
  logic           we;
  logic           frame_done;
  logic [7:0]     frame_cnt;

  ov7670_capture_dec #(
    .C_IMG_COLS(COLS), .C_IMG_ROWS(ROWS), .C_DEC_SHIFT(DEC),
    .C_NB_IMG_PXLS(NBA), .C_NB_CNT(NBC)
  ) dut (
    .clk(clk), .rst_n(rst_n), .pclk(pclk), .vsync(vsync), .href(href),
    .data(data), .swap_r_b(swap_r_b), .freeze(freeze),
`ifdef CAPTURE_GRAY_EN
    .gray_mode(gray_mode),
`endif
    .addr(addr), .dout(dout), .we(we), .frame_done(frame_done), .frame_cnt(frame_cnt)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [NBA-1:0] addr;
    logic [15:0]    dout;
  } wr_t;

  typedef struct {
    logic [7:0]  hi;
    logic [7:0]  lo;
    logic        swap;
    logic        gray;
    logic [15:0] exp;
  } vec_t;

  wr_t  q[$];
  vec_t vecs[$];

  int nVec = 0;
  int nMiss = 0;
  int doneSeen = 0;
  int expDone = 0;
  int expCnt = 0;
  bit mSync = 0, mActive = 0, mFreeze = 0;
  int mWrites = 0, mLastAddr = 0, mCol = 0, mRow = 0;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    nVec++;
    if (act !== exp) begin
      nMiss++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Scoreboard: every write the DUT makes must match the oldest expected write.
  always @(negedge clk) begin
    if (frame_done === 1'b1) doneSeen++;
    if (we === 1'b1) begin
      if (q.size() == 0) checkOutput("unexpected_we", 32'd1, 32'd0);
      else begin
        wr_t e;
        e = q.pop_front();
        checkOutput("wr_addr", 32'(addr), 32'(e.addr));
        checkOutput("wr_dout", 32'(dout), 32'(e.dout));
      end
    end
  end

  initial begin
    #3_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic sendByte(input logic [7:0] b);
    data = b;
    pclk = 1'b0;
    step(1);
    pclk = 1'b1;
    step(1);
  endtask

  task automatic sendPixel(input logic [7:0] hi, input logic [7:0] lo, input logic [15:0] exp);
    sendByte(hi);
    sendByte(lo);
    if (mActive && !mFreeze && (mCol % (1 << DEC)) == 0 && (mRow % (1 << DEC)) == 0 &&
        (mCol >> DEC) < COLS && (mRow >> DEC) < ROWS && mWrites < TOTAL) begin
      q.push_back('{addr: NBA'(mWrites), dout: exp});
      mLastAddr = mWrites;
      mWrites++;
    end
    mCol++;
  endtask

  task automatic endLine();
    href = 1'b0;
    pclk = 1'b0;
    mRow++;
    step(6);
  endtask

  task automatic sendLine(input logic [7:0] hi, input logic [7:0] lo, input logic [15:0] exp);
    href = 1'b1;
    mCol = 0;
    for (int c = 0; c < CAM_COLS; c++) sendPixel(hi, lo, exp);
    endLine();
  endtask

  task automatic vsyncRise();
    href = 1'b0;
    pclk = 1'b0;
    vsync = 1'b1;
    if (mActive && mWrites == TOTAL) begin
      expDone++;
      expCnt = (expCnt + 1) % 256;
    end
    mFreeze = freeze;
    mWrites = 0;
    mLastAddr = 0;
    mActive = 0;
    mSync = 1;
    step(6);
  endtask

  task automatic vsyncFall();
    vsync = 1'b0;
    if (mSync) mActive = 1;
    mSync = 0;
    mRow = 0;
    step(6);
  endtask

  task automatic checkDone(input string tag);
    checkOutput({tag, "_done_pulses"}, 32'(doneSeen), 32'(expDone));
    checkOutput({tag, "_frame_cnt"}, 32'(frame_cnt), 32'(expCnt));
  endtask

  task automatic checkFrameEnd(input string tag);
    step(3);
    checkOutput({tag, "_pending_writes"}, 32'(q.size()), 32'd0);
    checkOutput({tag, "_last_addr"}, 32'(addr), 32'(mLastAddr));
  endtask

  task automatic applyStimulus(input logic [7:0] hi, input logic [7:0] lo, input logic [15:0] exp,
                               input int nLines);
    vsyncFall();
    for (int r = 0; r < nLines; r++) sendLine(hi, lo, exp);
  endtask

  initial begin
    vecs.push_back('{8'hF8, 8'h00, 1'b0, 1'b0, 16'hF800});
    vecs.push_back('{8'hF8, 8'h00, 1'b1, 1'b0, 16'h001F});
    vecs.push_back('{8'h07, 8'hE0, 1'b1, 1'b0, 16'h07E0});
    vecs.push_back('{8'h12, 8'h34, 1'b0, 1'b0, 16'h1234});
    vecs.push_back('{8'h12, 8'h34, 1'b1, 1'b0, 16'hA222});
    vecs.push_back('{8'h00, 8'h1F, 1'b1, 1'b0, 16'hF800});
`ifdef CAPTURE_GRAY_EN
    vecs.push_back('{8'hFF, 8'hFF, 1'b0, 1'b1, 16'h00FA});
    vecs.push_back('{8'h07, 8'hE0, 1'b0, 1'b1, 16'h007E});
`endif

    step(3);
    checkOutput("reset_we", 32'(we), 32'd0);
    checkOutput("reset_addr", 32'(addr), 32'd0);
    checkOutput("reset_dout", 32'(dout), 32'd0);
    checkOutput("reset_frame_done", 32'(frame_done), 32'd0);
    checkOutput("reset_frame_cnt", 32'(frame_cnt), 32'd0);
    rst_n = 1'b1;
    step(2);

    // One full frame per table entry; oversized lines and rows exercise the decimation window.
    foreach (vecs[i]) begin
      swap_r_b = vecs[i].swap;
`ifdef CAPTURE_GRAY_EN
      gray_mode = vecs[i].gray;
`endif
      vsyncRise();
      checkDone("table");
      applyStimulus(vecs[i].hi, vecs[i].lo, vecs[i].exp, CAM_ROWS);
      checkFrameEnd("table");
    end
    vsyncRise();
    checkDone("table_last");
    swap_r_b = 1'b0;
`ifdef CAPTURE_GRAY_EN
    gray_mode = 1'b0;
`endif

    // Freeze raised mid-frame only takes effect on the following frame.
    vsyncFall();
    for (int r = 0; r < CAM_ROWS / 2; r++) sendLine(8'hAB, 8'hCD, 16'hABCD);
    freeze = 1'b1;
    for (int r = CAM_ROWS / 2; r < CAM_ROWS; r++) sendLine(8'hAB, 8'hCD, 16'hABCD);
    checkFrameEnd("freeze_f1");
    vsyncRise();
    checkDone("freeze_f1");
    applyStimulus(8'h55, 8'h66, 16'h5566, CAM_ROWS);
    checkFrameEnd("freeze_f2");
    freeze = 1'b0;
    vsyncRise();
    checkDone("freeze_f2");

    // Early vsync rise with a half-received pixel: no frame_done, next frame restarts at 0.
    applyStimulus(8'h31, 8'h42, 16'h3142, 4);
    href = 1'b1;
    sendByte(8'h99);
    vsyncRise();
    checkFrameEnd("abort");
    checkDone("abort");
    applyStimulus(8'h0F, 8'hF0, 16'h0FF0, CAM_ROWS);
    checkFrameEnd("abort_next");
    vsyncRise();
    checkDone("abort_next");

    // Reset in the middle of a line, then recovery through a full SYNC -> ACTIVE sequence.
    applyStimulus(8'h24, 8'h68, 16'h2468, 3);
    href = 1'b1;
    mCol = 0;
    for (int c = 0; c < 4; c++) sendPixel(8'h24, 8'h68, 16'h2468);
    step(4);
    checkOutput("pre_reset_frame_cnt", 32'(frame_cnt), 32'(expCnt));
    rst_n = 1'b0;
    #1;
    checkOutput("rst_we", 32'(we), 32'd0);
    checkOutput("rst_addr", 32'(addr), 32'd0);
    checkOutput("rst_dout", 32'(dout), 32'd0);
    checkOutput("rst_frame_done", 32'(frame_done), 32'd0);
    checkOutput("rst_frame_cnt", 32'(frame_cnt), 32'd0);
    q.delete();
    mActive = 0;
    mSync = 0;
    mFreeze = 0;
    mWrites = 0;
    mLastAddr = 0;
    expDone = 0;
    doneSeen = 0;
    expCnt = 0;
    step(3);
    rst_n = 1'b1;
    for (int c = 4; c < CAM_COLS; c++) sendPixel(8'h24, 8'h68, 16'h2468);
    endLine();
    sendLine(8'h24, 8'h68, 16'h2468);
    checkFrameEnd("post_reset_idle");
    vsyncRise();
    checkDone("post_reset_rise");
    vsyncFall();
    href = 1'b1;
    mCol = 0;
    sendPixel(8'hC3, 8'h3C, 16'hC33C);
    step(1);
    checkOutput("latency_early", 32'(we), 32'd0);
    step(1);
    checkOutput("latency_we", 32'(we), 32'd1);
    for (int c = 1; c < CAM_COLS; c++) sendPixel(8'hC3, 8'h3C, 16'hC33C);
    endLine();
    for (int r = 1; r < CAM_ROWS; r++) sendLine(8'hC3, 8'h3C, 16'hC33C);
    checkFrameEnd("post_reset_frame");
    vsyncRise();
    checkDone("post_reset_frame");

    $display("== %0d vectors applied, %0d miscompares ==", nVec, nMiss);
    $finish;
  end

endmodule
